// File: rtl/cell_mem_arbiter_if.sv
// Agent-side bus of the cell memory arbiter: packed write requests in, one-hot grant and error pulse out.
// Agents sit on the master modport, the arbiter on the slave modport.
interface cell_mem_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDXW  = 5,
    parameter int CBITS = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*IDXW-1:0]  req_idx;
    logic [N_REQ*CBITS-1:0] req_col;
    logic [N_REQ-1:0]       gnt;
    logic                   err;

    modport master (
        output req,
        output req_idx,
        output req_col,
        input  gnt,
        input  err
    );

    modport slave (
        input  req,
        input  req_idx,
        input  req_col,
        output gnt,
        output err
    );
endinterface

// File: rtl/cell_mem_arbiter.sv
// Round-robin arbiter admitting one cell write per two cycles into a shadow grid,
// committed to pixelMemory once per frame on the vsync falling edge.
module cell_mem_arbiter #(
    parameter int N_REQ = 4,
    parameter int CELLS = 24,
    parameter int CBITS = 2,
    parameter int IDXW  = 5,
    parameter int MEMW  = 48
) (
    input  logic                 clk,
    input  logic                 rst_btn,
    input  logic                 vsync,
    cell_mem_arbiter_if.slave    bus,
    output logic [MEMW-1:0]      pixelMemory,
    output logic [7:0]           frame_cnt
);
    localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {ARB, WR, COMMIT} state_t;

    state_t            state_reg, state_next;
    logic [PTRW-1:0]   rr_ptr_reg;
    logic [PTRW-1:0]   win_reg, win_next;
    logic [IDXW-1:0]   idx_reg;
    logic [CBITS-1:0]  col_reg;
    logic              vsync_q_reg;
    logic              commit_pend_reg;
    logic [MEMW-1:0]   pix_reg;
    logic [7:0]        frame_cnt_reg;
    logic [MEMW-1:0]   shadow_flat;

    logic              frame_edge;
    logic              any_req;
    logic              latch_en;
    logic              wr_en;
    logic              commit_en;
    logic              idx_ok;
    logic [N_REQ-1:0]  win_onehot;

    logic [IDXW-1:0]   idx_arr [N_REQ];
    logic [CBITS-1:0]  col_arr [N_REQ];

    genvar gi;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign idx_arr[gi]    = bus.req_idx[gi*IDXW +: IDXW];
            assign col_arr[gi]    = bus.req_col[gi*CBITS +: CBITS];
            assign win_onehot[gi] = (win_reg == PTRW'(gi));
        end
    endgenerate

    assign frame_edge = vsync_q_reg & ~vsync;
    assign any_req    = |bus.req;
    assign idx_ok     = ({1'b0, idx_reg} < (IDXW+1)'(CELLS));

    // First requester at or after rr_ptr, wrapping around the agent ring.
    always_comb begin
        logic [PTRW:0] sum;
        logic          found;
        win_next = rr_ptr_reg;
        found    = 1'b0;
        sum      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr_reg} + (PTRW+1)'(i);
            if (sum >= (PTRW+1)'(N_REQ)) begin
                sum = sum - (PTRW+1)'(N_REQ);
            end
            if (!found && bus.req[sum[PTRW-1:0]]) begin
                win_next = sum[PTRW-1:0];
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_btn) begin
            state_reg <= ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    // A pending commit outranks any request so the frame is never delayed by agents.
    always_comb begin
        state_next = ARB;
        case (state_reg)
            ARB: begin
                if (commit_pend_reg) begin
                    state_next = COMMIT;
                end else if (any_req) begin
                    state_next = WR;
                end else begin
                    state_next = ARB;
                end
            end
            WR:      state_next = ARB;
            COMMIT:  state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        bus.gnt   = '0;
        bus.err   = 1'b0;
        latch_en  = 1'b0;
        wr_en     = 1'b0;
        commit_en = 1'b0;
        case (state_reg)
            ARB: begin
                latch_en = !commit_pend_reg && any_req;
            end
            WR: begin
                bus.gnt = win_onehot;
                wr_en   = idx_ok;
                bus.err = !idx_ok;
            end
            COMMIT: begin
                commit_en = 1'b1;
            end
            default: begin
                latch_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_btn) begin
            rr_ptr_reg      <= '0;
            win_reg         <= '0;
            idx_reg         <= '0;
            col_reg         <= '0;
            vsync_q_reg     <= 1'b1;
            commit_pend_reg <= 1'b0;
            pix_reg         <= '0;
            frame_cnt_reg   <= '0;
        end else begin
            vsync_q_reg <= vsync;
            if (latch_en) begin
                win_reg <= win_next;
                idx_reg <= idx_arr[win_next];
                col_reg <= col_arr[win_next];
            end
            if (state_reg == WR) begin
                rr_ptr_reg <= (win_reg == PTRW'(N_REQ-1)) ? '0 : win_reg + 1'b1;
            end
            // An edge arriving in the commit cycle itself must survive the clear.
            if (frame_edge) begin
                commit_pend_reg <= 1'b1;
            end else if (commit_en) begin
                commit_pend_reg <= 1'b0;
            end
            if (commit_en) begin
                pix_reg       <= shadow_flat;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [CBITS-1:0] cell_reg;
            always_ff @(posedge clk) begin
                if (rst_btn) begin
                    cell_reg <= '0;
                end else if (wr_en && (idx_reg == IDXW'(gi))) begin
                    cell_reg <= col_reg;
                end
            end
            assign shadow_flat[gi*CBITS +: CBITS] = cell_reg;
        end
    endgenerate

    assign pixelMemory = pix_reg;
    assign frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Directed bench for cell_mem_arbiter: a table of single-agent writes with commits,
// followed by hand-written sequences for round-robin, vsync-in-WR, wrap and reset-mid-WR.
module tb_cell_mem_arbiter;
    logic        clk;
    logic        rst_btn;
    logic        vsync;
    logic [47:0] pixelMemory;
    logic [7:0]  frame_cnt;

    int checks;
    int errors;

    cell_mem_arbiter_if #(.N_REQ(4), .IDXW(5), .CBITS(2)) bus_if ();

    cell_mem_arbiter #(
        .N_REQ(4), .CELLS(24), .CBITS(2), .IDXW(5), .MEMW(48)
    ) dut (
        .clk         (clk),
        .rst_btn     (rst_btn),
        .vsync       (vsync),
        .bus         (bus_if),
        .pixelMemory (pixelMemory),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          agent;
        logic [4:0]  idx;
        logic [1:0]  col;
        logic [3:0]  exp_gnt;
        logic        exp_err;
        logic        do_commit;
        logic [47:0] exp_pix;
        logic [7:0]  exp_fc;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_btn = 1'b1;
        tick();
        rst_btn = 1'b0;
    endtask

    task automatic drive_req(input int agent, input logic [4:0] idx, input logic [1:0] col);
        bus_if.req                     = '0;
        bus_if.req[agent]              = 1'b1;
        bus_if.req_idx[agent*5 +: 5]   = idx;
        bus_if.req_col[agent*2 +: 2]   = col;
    endtask

    // vsync low for three cycles: edge registered, then ARB->COMMIT, then commit lands.
    task automatic do_frame();
        vsync = 1'b0;
        tick();
        tick();
        tick();
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        logic [3:0]  rr_exp [9];
        logic [47:0] prev_pix;

        checks         = 0;
        errors         = 0;
        rst_btn        = 1'b1;
        vsync          = 1'b1;
        bus_if.req     = '0;
        bus_if.req_idx = '0;
        bus_if.req_col = '0;

        //            agent idx    col    gnt      err   commit exp_pix              fc
        vecs[0] = '{0, 5'd3,  2'b11, 4'b0001, 1'b0, 1'b1, 48'h0000_0000_00C0, 8'd1};
        vecs[1] = '{1, 5'd0,  2'b01, 4'b0010, 1'b0, 1'b0, 48'h0000_0000_00C0, 8'd1};
        vecs[2] = '{2, 5'd24, 2'b10, 4'b0100, 1'b1, 1'b1, 48'h0000_0000_00C1, 8'd2};
        vecs[3] = '{3, 5'd23, 2'b10, 4'b1000, 1'b0, 1'b0, 48'h0000_0000_00C1, 8'd2};
        vecs[4] = '{2, 5'd31, 2'b11, 4'b0100, 1'b1, 1'b0, 48'h0000_0000_00C1, 8'd2};
        vecs[5] = '{0, 5'd3,  2'b01, 4'b0001, 1'b0, 1'b1, 48'h8000_0000_0041, 8'd3};

        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // Reset idle: nothing moves for 20 cycles.
        tick();
        tick();
        rst_btn = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("idle_pix", 64'(pixelMemory), 64'h0);
            check("idle_fc",  64'(frame_cnt),   64'h0);
            check("idle_gnt", 64'(bus_if.gnt),  64'h0);
            tick();
        end
        $display("reset idle: pix=0x%0h fc=%0d gnt=%b", pixelMemory, frame_cnt, bus_if.gnt);

        // Table of single-agent writes with selected commits.
        prev_pix = '0;
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i].agent, vecs[i].idx, vecs[i].col);
            tick();
            $display("vec %0d agent=%0d idx=%0d col=%b gnt=%b err=%b",
                     i, vecs[i].agent, vecs[i].idx, vecs[i].col, bus_if.gnt, bus_if.err);
            check("vec_gnt", 64'(bus_if.gnt), 64'(vecs[i].exp_gnt));
            check("vec_err", 64'(bus_if.err), 64'(vecs[i].exp_err));
            bus_if.req = '0;
            tick();
            check("vec_gnt_off", 64'(bus_if.gnt), 64'h0);
            check("vec_pix_hold", 64'(pixelMemory), 64'(prev_pix));
            if (vecs[i].do_commit) begin
                do_frame();
            end
            check("vec_pix", 64'(pixelMemory), 64'(vecs[i].exp_pix));
            check("vec_fc",  64'(frame_cnt),   64'(vecs[i].exp_fc));
            prev_pix = vecs[i].exp_pix;
        end

        // All agents hold req: grants 0,1,2,3,0 two cycles apart.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus_if.req_idx[k*5 +: 5] = 5'(8 + k);
            bus_if.req_col[k*2 +: 2] = 2'(k);
        end
        bus_if.req = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            tick();
            $display("rr cycle %0d gnt=%b", c, bus_if.gnt);
            check("rr_gnt", 64'(bus_if.gnt), 64'(rr_exp[c]));
        end
        bus_if.req = '0;
        tick();
        do_frame();
        check("rr_pix", 64'(pixelMemory), 64'h0000_0000_00E4_0000);
        check("rr_fc",  64'(frame_cnt),   64'h1);

        // vsync edge inside the WR cycle of agent 1: write joins the same commit.
        do_reset();
        drive_req(1, 5'd0, 2'b01);
        tick();
        check("vw_gnt", 64'(bus_if.gnt), 64'b0010);
        vsync      = 1'b0;
        bus_if.req = '0;
        tick();
        tick();
        check("vw_pix_pre", 64'(pixelMemory), 64'h0);
        tick();
        vsync = 1'b1;
        $display("vsync-in-WR: pix=0x%0h fc=%0d", pixelMemory, frame_cnt);
        check("vw_pix", 64'(pixelMemory), 64'h1);
        check("vw_fc",  64'(frame_cnt),   64'h1);
        tick();

        // 256 empty frames wrap frame_cnt.
        do_reset();
        for (int f = 0; f < 255; f++) begin
            do_frame();
        end
        check("wrap_fc_255", 64'(frame_cnt), 64'd255);
        do_frame();
        $display("wrap: fc=%0d", frame_cnt);
        check("wrap_fc_0", 64'(frame_cnt), 64'd0);

        // Reset during WR discards the write; held req is re-arbitrated afterwards.
        drive_req(0, 5'd5, 2'b11);
        tick();
        check("rw_gnt_pre", 64'(bus_if.gnt), 64'b0001);
        rst_btn = 1'b1;
        tick();
        rst_btn = 1'b0;
        check("rw_gnt_rst", 64'(bus_if.gnt),  64'h0);
        check("rw_pix_rst", 64'(pixelMemory), 64'h0);
        check("rw_fc_rst",  64'(frame_cnt),   64'h0);
        tick();
        check("rw_gnt_again", 64'(bus_if.gnt), 64'b0001);
        bus_if.req = '0;
        tick();
        do_frame();
        $display("reset-mid-WR: pix=0x%0h fc=%0d", pixelMemory, frame_cnt);
        check("rw_pix", 64'(pixelMemory), 64'h0000_0000_0C00);
        check("rw_fc",  64'(frame_cnt),   64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
